// File: rtl/tdc_thermo_accum_if.sv
// Result handshake bundle for the thermometer TDC accumulator.
// The core drives the result through master; the consumer uses slave.
interface tdc_thermo_accum_if #(
   parameter int TAPS     = 8,
   parameter int AVG_LOG2 = 3
);
   localparam int CODE_W = $clog2(TAPS + 1);
   localparam int ACC_W  = CODE_W + AVG_LOG2;

   logic                res_valid;
   logic                res_ready;
   logic [ACC_W-1:0]    res_sum;
   logic [CODE_W-1:0]   res_avg;
   logic [CODE_W-1:0]   res_min;
   logic [CODE_W-1:0]   res_max;
   logic [AVG_LOG2:0]   bubble_cnt;

   modport master (
      output res_valid, res_sum, res_avg,
      output res_min, res_max, bubble_cnt,
      input  res_ready
   );

   modport slave (
      input  res_valid, res_sum, res_avg,
      input  res_min, res_max, bubble_cnt,
      output res_ready
   );
endinterface

// File: rtl/tdc_thermo_accum.sv
// Thermometer-code TDC sampler: synchronises taps, popcounts them and
// accumulates 2^AVG_LOG2 samples into sum/avg/min/max/bubble statistics.
module tdc_thermo_accum #(
   parameter int TAPS     = 8,
   parameter int AVG_LOG2 = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [TAPS-1:0] term,
   input  logic            meas_strobe,
   input  logic            cmd_start,
   output logic            busy,
   tdc_thermo_accum_if.master res
);
   localparam int CODE_W = $clog2(TAPS + 1);
   localparam int ACC_W  = CODE_W + AVG_LOG2;
   localparam int CNT_W  = AVG_LOG2 + 1;
   localparam int N      = 1 << AVG_LOG2;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t            state;
   logic [TAPS-1:0]   sync1, sync2;
   logic              stb1, stb2;
   logic [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;
   logic [CODE_W-1:0] mn, mx;
   logic [CNT_W-1:0]  bub;
   logic              valid;
   logic [CODE_W-1:0] code;
   logic              bubble;

   always_comb begin
      code = '0;
      for (int i = 0; i < TAPS; i++)
         code = code + CODE_W'(sync2[i]);
   end

   // A one above a zero anywhere breaks the thermometer shape.
   assign bubble = |(sync2[TAPS-1:1] & ~sync2[TAPS-2:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sync1 <= '0;
         sync2 <= '0;
         stb1  <= 1'b0;
         stb2  <= 1'b0;
         acc   <= '0;
         cnt   <= '0;
         mn    <= '0;
         mx    <= '0;
         bub   <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
      end else begin
         sync1 <= term;
         sync2 <= sync1;
         stb1  <= meas_strobe;
         stb2  <= stb1;
         unique case (state)
            IDLE: begin
               if (cmd_start) begin
                  state <= ACCUM;
                  busy  <= 1'b1;
                  acc   <= '0;
                  cnt   <= '0;
                  bub   <= '0;
                  mn    <= '1;
                  mx    <= '0;
                  stb1  <= 1'b0;
                  stb2  <= 1'b0;
               end
            end
            ACCUM: begin
               if (stb2) begin
                  acc <= acc + ACC_W'(code);
                  cnt <= cnt + 1'b1;
                  if (code < mn) mn <= code;
                  if (code > mx) mx <= code;
                  if (bubble) bub <= bub + 1'b1;
                  if (cnt == LAST) begin
                     state <= DONE;
                     valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (res.res_ready) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  valid <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               valid <= 1'b0;
            end
         endcase
      end
   end

   assign res.res_valid  = valid;
   assign res.res_sum    = acc;
   assign res.res_avg    = CODE_W'(acc >> AVG_LOG2);
   assign res.res_min    = mn;
   assign res.res_max    = mx;
   assign res.bubble_cnt = bub;
endmodule

// File: tb/tb_tdc_thermo_accum.sv
// Bench for tdc_thermo_accum: vector table, random runs against a
// popcount/shape model, and hand sequences for hold and abort.
module tb_tdc_thermo_accum;
   localparam int TAPS = 8;
   localparam int AVG_LOG2 = 3;
   localparam int N = 8;

   logic clk = 1'b0;
   logic rst;
   logic [TAPS-1:0] term;
   logic meas_strobe;
   logic cmd_start;
   logic busy;

   tdc_thermo_accum_if #(.TAPS(TAPS), .AVG_LOG2(AVG_LOG2)) rif ();

   tdc_thermo_accum #(.TAPS(TAPS), .AVG_LOG2(AVG_LOG2)) dut (
      .clk(clk),
      .rst(rst),
      .term(term),
      .meas_strobe(meas_strobe),
      .cmd_start(cmd_start),
      .busy(busy),
      .res(rif.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] t [8];
      int sum;
      int avg;
      int mn;
      int mx;
      int bub;
   } vec_t;

   vec_t vec [5];
   logic [7:0] cur [8];
   int total = 0;
   int bad = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_res(input string tag, input int s, input int a,
                          input int mn, input int mx, input int b);
      chk({tag, " sum"}, int'(rif.res_sum), s);
      chk({tag, " avg"}, int'(rif.res_avg), a);
      chk({tag, " min"}, int'(rif.res_min), mn);
      chk({tag, " max"}, int'(rif.res_max), mx);
      chk({tag, " bub"}, int'(rif.bubble_cnt), b);
   endtask

   // Issue cmd_start then the eight samples in cur; gap_pct inserts idle cycles.
   task automatic do_run(input int gap_pct);
      cmd_start = 1'b1;
      step();
      cmd_start = 1'b0;
      for (int i = 0; i < N; i++) begin
         while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            meas_strobe = 1'b0;
            term = 8'($urandom);
            step();
         end
         term = cur[i];
         meas_strobe = 1'b1;
         step();
      end
      meas_strobe = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input bit noise, output int lat);
      lat = 0;
      while (!rif.res_valid && lat < 20) begin
         meas_strobe = noise ? 1'($urandom) : 1'b0;
         term = 8'($urandom);
         step();
         lat++;
      end
      meas_strobe = 1'b0;
      if (!rif.res_valid) begin
         total++;
         bad++;
         $display("FAIL %s timeout: res_valid=0 after %0d cycles, required 1", tag, lat);
      end
   endtask

   task automatic accept(input string tag);
      rif.res_ready = 1'b1;
      step();
      rif.res_ready = 1'b0;
      chk({tag, " busy after accept"}, int'(busy), 0);
      chk({tag, " valid after accept"}, int'(rif.res_valid), 0);
   endtask

   // Reference: code = count of ones; a sample is clean only if it equals 2^code-1.
   task automatic model(output int s, output int a, output int mn,
                        output int mx, output int b);
      int c;
      s = 0; b = 0; mn = TAPS + 100; mx = -1;
      for (int i = 0; i < N; i++) begin
         c = $countones(cur[i]);
         s += c;
         if (c < mn) mn = c;
         if (c > mx) mx = c;
         if (int'(cur[i]) != (1 << c) - 1) b++;
      end
      a = s / N;
   endtask

   initial begin
      int lat, s, a, mn, mx, b;
      rst = 1'b1;
      term = '0;
      meas_strobe = 1'b0;
      cmd_start = 1'b0;
      rif.res_ready = 1'b0;

      vec[0].t = '{8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
      vec[0].sum = 32; vec[0].avg = 4; vec[0].mn = 4; vec[0].mx = 4; vec[0].bub = 0;
      vec[1].t = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F};
      vec[1].sum = 28; vec[1].avg = 3; vec[1].mn = 0; vec[1].mx = 7; vec[1].bub = 0;
      vec[2].t = '{8'h17, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
      vec[2].sum = 32; vec[2].avg = 4; vec[2].mn = 4; vec[2].mx = 4; vec[2].bub = 1;
      vec[3].t = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      vec[3].sum = 64; vec[3].avg = 8; vec[3].mn = 8; vec[3].mx = 8; vec[3].bub = 0;
      vec[4].t = '{8'h02, 8'h00, 8'hFF, 8'h05, 8'h80, 8'h0F, 8'h03, 8'h01};
      vec[4].sum = 19; vec[4].avg = 2; vec[4].mn = 0; vec[4].mx = 8; vec[4].bub = 3;

      step();
      step();
      rst = 1'b0;
      chk("reset busy", int'(busy), 0);
      chk("reset valid", int'(rif.res_valid), 0);
      chk_res("reset", 0, 0, 0, 0, 0);

      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < N; i++) cur[i] = vec[v].t[i];
         do_run(0);
         chk($sformatf("vec%0d busy", v), int'(busy), 1);
         wait_valid($sformatf("vec%0d", v), 1'b0, lat);
         chk($sformatf("vec%0d latency", v), lat, 2);
         chk_res($sformatf("vec%0d", v), vec[v].sum, vec[v].avg,
                 vec[v].mn, vec[v].mx, vec[v].bub);
         accept($sformatf("vec%0d", v));
      end

      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(2))
               0: cur[i] = 8'($urandom);
               1: cur[i] = 8'((1 << $urandom_range(8)) - 1);
               default: cur[i] = 8'(((1 << $urandom_range(8)) - 1) ^ (1 << $urandom_range(7)));
            endcase
         end
         model(s, a, mn, mx, b);
         do_run(35);
         wait_valid($sformatf("rnd%0d", r), 1'b1, lat);
         chk_res($sformatf("rnd%0d", r), s, a, mn, mx, b);
         accept($sformatf("rnd%0d", r));
      end

      for (int i = 0; i < N; i++) cur[i] = 8'h0F;
      do_run(0);
      wait_valid("hold", 1'b0, lat);
      for (int c = 0; c < 5; c++) begin
         meas_strobe = 1'b1;
         term = 8'hFF;
         cmd_start = 1'(c % 2);
         step();
         chk($sformatf("hold%0d valid", c), int'(rif.res_valid), 1);
         chk($sformatf("hold%0d busy", c), int'(busy), 1);
         chk_res($sformatf("hold%0d", c), 32, 4, 4, 4, 0);
      end
      meas_strobe = 1'b0;
      cmd_start = 1'b0;
      accept("hold");
      step();
      chk_res("idle keeps", 32, 4, 4, 4, 0);

      cmd_start = 1'b1;
      step();
      cmd_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         term = 8'hFF;
         meas_strobe = 1'b1;
         step();
      end
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      meas_strobe = 1'b0;
      chk("abort busy", int'(busy), 0);
      chk("abort valid", int'(rif.res_valid), 0);
      chk_res("abort", 0, 0, 0, 0, 0);
      step();
      step();
      chk("abort stays idle", int'(busy), 0);

      for (int i = 0; i < N; i++) cur[i] = 8'hFF;
      do_run(0);
      wait_valid("fresh", 1'b0, lat);
      chk("fresh latency", lat, 2);
      chk_res("fresh", 64, 8, 8, 8, 0);
      accept("fresh");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
